// File: rtl/led_activity_scheduler.sv
// Shares one LED among NUM_SRC activity sources. Source k is shown as k+1 blinks
// followed by a dark gap; sources are served in round-robin order from sticky flags.
module led_activity_scheduler #(
    parameter int NUM_SRC     = 4,
    parameter int PHASE_WIDTH = 24,
    localparam int SRC_W      = (NUM_SRC <= 2) ? 1 : $clog2(NUM_SRC)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_SRC-1:0] trigger,
    output logic               led_out,
    output logic               busy,
    output logic [SRC_W-1:0]   active_src,
    output logic [NUM_SRC-1:0] pending
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        OFF  = 2'd2,
        GAP  = 2'd3
    } state_t;

    // Terminal counts built from replicated ones so PHASE_WIDTH=30 cannot overflow an int.
    localparam logic [PHASE_WIDTH:0] PHASE_LAST = {1'b0, {PHASE_WIDTH{1'b1}}};
    localparam logic [PHASE_WIDTH:0] GAP_LAST   = {(PHASE_WIDTH+1){1'b1}};
    localparam logic [PHASE_WIDTH:0] PHASE_ONE  = (PHASE_WIDTH+1)'(1);
    localparam logic [SRC_W-1:0]     SRC_LAST   = SRC_W'(NUM_SRC - 1);
    localparam logic [SRC_W-1:0]     SRC_ONE    = SRC_W'(1);

    state_t               state;
    logic [SRC_W-1:0]     rr_ptr;
    logic [PHASE_WIDTH:0] phase_cnt;
    logic [SRC_W-1:0]     pulse_cnt;

    logic                 found;
    logic [SRC_W-1:0]     grant_idx;
    logic [NUM_SRC-1:0]   grant_mask;

    // First set pending bit at or after rr_ptr, wrapping past NUM_SRC-1 back to 0.
    always_comb begin
        int cand;
        cand      = 0;
        found     = 1'b0;
        grant_idx = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            cand = int'(rr_ptr) + i;
            if (cand >= NUM_SRC) cand = cand - NUM_SRC;
            if (!found && pending[cand]) begin
                found     = 1'b1;
                grant_idx = SRC_W'(cand);
            end
        end
    end

    always_comb begin
        grant_mask = '0;
        if (state == IDLE && found) grant_mask[grant_idx] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            led_out    <= 1'b0;
            busy       <= 1'b0;
            active_src <= '0;
            pending    <= '0;
            rr_ptr     <= '0;
            phase_cnt  <= '0;
            pulse_cnt  <= '0;
        end else begin
            // A trigger on the grant edge re-arms the flag the grant clears.
            pending <= (pending & ~grant_mask) | trigger;

            case (state)
                IDLE: begin
                    if (found) begin
                        active_src <= grant_idx;
                        rr_ptr     <= (grant_idx == SRC_LAST) ? '0 : grant_idx + SRC_ONE;
                        phase_cnt  <= '0;
                        pulse_cnt  <= '0;
                        led_out    <= 1'b1;
                        busy       <= 1'b1;
                        state      <= ON;
                    end
                end
                ON: begin
                    if (phase_cnt == PHASE_LAST) begin
                        phase_cnt <= '0;
                        led_out   <= 1'b0;
                        state     <= OFF;
                    end else begin
                        phase_cnt <= phase_cnt + PHASE_ONE;
                    end
                end
                OFF: begin
                    if (phase_cnt == PHASE_LAST) begin
                        phase_cnt <= '0;
                        if (pulse_cnt == active_src) begin
                            state <= GAP;
                        end else begin
                            pulse_cnt <= pulse_cnt + SRC_ONE;
                            led_out   <= 1'b1;
                            state     <= ON;
                        end
                    end else begin
                        phase_cnt <= phase_cnt + PHASE_ONE;
                    end
                end
                GAP: begin
                    if (phase_cnt == GAP_LAST) begin
                        phase_cnt <= '0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end else begin
                        phase_cnt <= phase_cnt + PHASE_ONE;
                    end
                end
                default: begin
                    state   <= IDLE;
                    busy    <= 1'b0;
                    led_out <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_led_activity_scheduler.sv
// Directed bench for led_activity_scheduler with PHASE_WIDTH=2, NUM_SRC=4:
// expected grant order is queued at stimulus time and checked per observed service.
module tb_led_activity_scheduler;

    localparam int NUM_SRC     = 4;
    localparam int PHASE_WIDTH = 2;
    localparam int PH          = 1 << PHASE_WIDTH;

    logic                 clk;
    logic                 rst_n;
    logic [NUM_SRC-1:0]   trigger;
    logic                 led_out;
    logic                 busy;
    logic [1:0]           active_src;
    logic [NUM_SRC-1:0]   pending;

    logic [NUM_SRC-1:0]   trig_base;
    logic [1:0]           exp_q[$];
    int                   n_checks;
    int                   n_fail;

    led_activity_scheduler #(
        .NUM_SRC     (NUM_SRC),
        .PHASE_WIDTH (PHASE_WIDTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .trigger    (trigger),
        .led_out    (led_out),
        .busy       (busy),
        .active_src (active_src),
        .pending    (pending)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        trigger   = '0;
        trig_base = '0;
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Waits (at negedges) for busy to rise; returns the number of cycles waited.
    task automatic wait_grant(output int waited);
        waited = 0;
        while (!busy && waited < 300) begin
            @(negedge clk);
            waited++;
        end
        chk("grant_timeout", {31'd0, busy}, 32'd1);
    endtask

    // Called at the first negedge of a service; inject is added to trigger for that cycle.
    task automatic measure_service(input string tag, input logic [NUM_SRC-1:0] inject);
        int        cyc;
        int        pulses;
        int        highs;
        logic      prev;
        logic [1:0] src_exp;
        logic [1:0] src_obs;
        cyc = 0; pulses = 0; highs = 0; prev = 1'b0;
        src_exp = 2'd0;
        src_obs = active_src;
        n_checks++;
        assert (exp_q.size() > 0) else begin
            n_fail++;
            $error("FAIL %s_queue: observed 0 expected entries", tag);
        end
        if (exp_q.size() > 0) src_exp = exp_q.pop_front();
        trigger = trig_base | inject;
        while (busy && cyc < 400) begin
            cyc++;
            if (led_out) highs++;
            if (led_out && !prev) pulses++;
            prev = led_out;
            @(negedge clk);
            trigger = trig_base;
        end
        chk({tag, "_src"}, 32'(src_obs), 32'(src_exp));
        chk({tag, "_pulses"}, 32'(pulses), 32'(src_exp) + 32'd1);
        chk({tag, "_led_high"}, 32'(highs), (32'(src_exp) + 32'd1) * PH);
        chk({tag, "_busy_cycles"}, 32'(cyc), (32'(src_exp) + 32'd2) * 2 * PH);
    endtask

    initial begin
        int   waited;
        logic led_seen;
        logic busy_seen;
        n_checks  = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        trigger   = '0;
        trig_base = '0;

        // Reset state before any clock edge
        #2;
        chk("rst_led", {31'd0, led_out}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_src", 32'(active_src), 32'd0);
        chk("rst_pending", 32'(pending), 32'd0);
        do_reset();

        // Single request on source 2
        trigger = 4'b0100;
        exp_q.push_back(2'd2);
        @(negedge clk);
        trigger = '0;
        chk("single_pending_set", 32'(pending), 32'b0100);
        chk("single_not_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        chk("single_busy", {31'd0, busy}, 32'd1);
        chk("single_led_on", {31'd0, led_out}, 32'd1);
        chk("single_pending_clr", 32'(pending), 32'd0);
        measure_service("single", '0);
        chk("single_idle_led", {31'd0, led_out}, 32'd0);

        // Round-robin over all sources from rr_ptr=0
        do_reset();
        trigger = 4'b1111;
        for (int k = 0; k < 4; k++) exp_q.push_back(2'(k));
        @(negedge clk);
        trigger = '0;
        wait_grant(waited);
        chk("rr_first_wait", 32'(waited), 32'd1);
        measure_service("rr0", '0);
        for (int k = 1; k < 4; k++) begin
            wait_grant(waited);
            chk("rr_gap", 32'(waited), 32'd1);
            measure_service("rr", '0);
        end

        // Re-trigger of source 0 during its own ON phase
        do_reset();
        trigger = 4'b0011;
        exp_q.push_back(2'd0);
        exp_q.push_back(2'd1);
        exp_q.push_back(2'd0);
        @(negedge clk);
        trigger = '0;
        wait_grant(waited);
        measure_service("retrig0", 4'b0001);
        wait_grant(waited);
        chk("retrig_gap1", 32'(waited), 32'd1);
        measure_service("retrig1", '0);
        wait_grant(waited);
        chk("retrig_gap2", 32'(waited), 32'd1);
        measure_service("retrig0b", '0);

        // Trigger held through the grant edge of source 1
        do_reset();
        trigger = 4'b0010;
        exp_q.push_back(2'd1);
        exp_q.push_back(2'd1);
        @(negedge clk);
        @(negedge clk);
        trigger = '0;
        chk("simul_busy", {31'd0, busy}, 32'd1);
        chk("simul_pending_kept", 32'(pending), 32'b0010);
        measure_service("simul_a", '0);
        wait_grant(waited);
        chk("simul_gap", 32'(waited), 32'd1);
        measure_service("simul_b", '0);
        chk("simul_pending_end", 32'(pending), 32'd0);

        // Asynchronous reset during the second OFF phase of source 1
        do_reset();
        trigger = 4'b0010;
        @(negedge clk);
        trigger = '0;
        wait_grant(waited);
        trigger = 4'b1000;
        @(negedge clk);
        trigger = '0;
        repeat (4 * PH - 3) @(negedge clk);
        chk("midrst_pre_busy", {31'd0, busy}, 32'd1);
        chk("midrst_pre_led", {31'd0, led_out}, 32'd0);
        chk("midrst_pre_pending", 32'(pending), 32'b1000);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_led", {31'd0, led_out}, 32'd0);
        chk("midrst_pending", 32'(pending), 32'd0);
        chk("midrst_src", 32'(active_src), 32'd0);
        trigger = 4'b0001;
        repeat (2) @(negedge clk);
        trigger = '0;
        rst_n = 1'b1;
        led_seen = 1'b0;
        busy_seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            led_seen  = led_seen | led_out;
            busy_seen = busy_seen | busy;
        end
        chk("postrst_led", {31'd0, led_seen}, 32'd0);
        chk("postrst_busy", {31'd0, busy_seen}, 32'd0);
        chk("postrst_pending", 32'(pending), 32'd0);

        // First trigger after release is honoured
        trigger = 4'b0001;
        exp_q.push_back(2'd0);
        @(negedge clk);
        trigger = '0;
        chk("postrst_trig", 32'(pending), 32'b0001);
        wait_grant(waited);
        measure_service("postrst_srv", '0);

        // Starvation: source 0 held, single pulse on source 3
        do_reset();
        trig_base = 4'b0001;
        trigger   = trig_base;
        exp_q.push_back(2'd0);
        exp_q.push_back(2'd3);
        exp_q.push_back(2'd0);
        @(negedge clk);
        wait_grant(waited);
        measure_service("starve0", 4'b1000);
        wait_grant(waited);
        chk("starve_gap", 32'(waited), 32'd1);
        measure_service("starve3", '0);
        wait_grant(waited);
        measure_service("starve0b", '0);
        trig_base = '0;
        trigger   = '0;
        do_reset();

        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
